// File: rtl/slime_freeze_ctrl.sv
//----------------------------------------------------------------------------
// Module : slime_freeze_ctrl
// Desc   : Per-slime freeze/thaw controller triggered by the player landing on
//          a slime top. Optional macro FREEZE_EXTEND_EN lets a fresh landing
//          during FROZEN/THAW reload the freeze timer.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module slime_freeze_ctrl #(
   parameter int N_SLIME      = 4,
   parameter int FOOT_X       = 24,
   parameter int FOOT_Y       = 41,
   parameter int SLIM_W       = 62,
   parameter int Y_TOL        = 2,
   parameter int FREEZE_TICKS = 180,
   parameter int THAW_TICKS   = 60
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_tick,
   input  logic [9:0]            x_blue,
   input  logic [8:0]            y_blue,
   input  logic [10*N_SLIME-1:0] x_slim,
   input  logic [9*N_SLIME-1:0]  y_slim,
   input  logic [N_SLIME-1:0]    slim_alive,
   output logic [N_SLIME-1:0]    frozen,
   output logic [N_SLIME-1:0]    thawing,
   output logic                  any_frozen,
   output logic                  freeze_evt
);

   localparam int TW = $clog2(FREEZE_TICKS + 1);
   localparam logic [TW-1:0] c_freeze = TW'(FREEZE_TICKS);
   localparam logic [TW-1:0] c_thaw   = TW'(THAW_TICKS);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FROZEN = 2'd1,
      ST_THAW   = 2'd2
   } state_t;

   logic [10:0]        w_fx;
   logic [10:0]        w_fy;
   logic [N_SLIME-1:0] w_hit;
   logic [N_SLIME-1:0] w_rise;
   logic [N_SLIME-1:0] w_enter;
   logic [N_SLIME-1:0] r_contact_q;
   logic [N_SLIME-1:0] r_contact_prev;
   logic               r_freeze_evt;

   // All geometry in 11 bits so sums never wrap.
   assign w_fx = {1'b0, x_blue} + 11'(FOOT_X);
   assign w_fy = {2'b0, y_blue} + 11'(FOOT_Y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_contact_q    <= '0;
         r_contact_prev <= '0;
         r_freeze_evt   <= 1'b0;
      end else begin
         r_contact_q    <= w_hit;
         r_contact_prev <= r_contact_q & slim_alive;
         r_freeze_evt   <= |w_enter;
      end
   end

   assign w_rise     = r_contact_q & ~r_contact_prev;
   assign freeze_evt = r_freeze_evt;
   assign any_frozen = |frozen;

   generate
      for (genvar i = 0; i < N_SLIME; i++) begin : g_ch
         logic [10:0]   w_xs;
         logic [10:0]   w_ys;
         state_t        r_state;
         state_t        w_state_nx;
         logic [TW-1:0] r_timer;
         logic [TW-1:0] w_timer_nx;
         logic [TW-1:0] w_dec;
         logic          w_enter_ch;

         assign w_xs = {1'b0, x_slim[10*i +: 10]};
         assign w_ys = {2'b0, y_slim[9*i +: 9]};

         // Lower y bound moved to the left side so small y_slim cannot underflow.
         assign w_hit[i] = slim_alive[i]
                         & (w_fx > w_xs) & (w_fx < w_xs + 11'(SLIM_W))
                         & (w_fy + 11'(Y_TOL) > w_ys) & (w_fy < w_ys + 11'(Y_TOL));

         assign w_dec = r_timer - TW'(1);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state <= ST_ACTIVE;
               r_timer <= '0;
            end else begin
               r_state <= w_state_nx;
               r_timer <= w_timer_nx;
            end
         end

         always_comb begin
            w_state_nx = r_state;
            w_timer_nx = r_timer;
            w_enter_ch = 1'b0;
            if (!slim_alive[i]) begin
               w_state_nx = ST_ACTIVE;
               w_timer_nx = '0;
            end else begin
               case (r_state)
                  ST_ACTIVE: begin
                     if (w_rise[i]) begin
                        w_state_nx = ST_FROZEN;
                        w_timer_nx = c_freeze;
                        w_enter_ch = 1'b1;
                     end
                  end
                  ST_FROZEN: begin
`ifdef FREEZE_EXTEND_EN
                     if (w_rise[i]) begin
                        w_timer_nx = c_freeze;
                        w_enter_ch = 1'b1;
                     end else
`endif
                     if (frame_tick) begin
                        w_timer_nx = w_dec;
                        if (w_dec == c_thaw) w_state_nx = ST_THAW;
                     end
                  end
                  ST_THAW: begin
`ifdef FREEZE_EXTEND_EN
                     if (w_rise[i]) begin
                        w_state_nx = ST_FROZEN;
                        w_timer_nx = c_freeze;
                        w_enter_ch = 1'b1;
                     end else
`endif
                     if (frame_tick) begin
                        w_timer_nx = w_dec;
                        if (w_dec == '0) w_state_nx = ST_ACTIVE;
                     end
                  end
                  default: begin
                     w_state_nx = ST_ACTIVE;
                     w_timer_nx = '0;
                  end
               endcase
            end
         end

         assign w_enter[i] = w_enter_ch;
         assign frozen[i]  = (r_state != ST_ACTIVE);
         assign thawing[i] = (r_state == ST_THAW);
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_slime_freeze_ctrl.sv
//----------------------------------------------------------------------------
// Module : tb_slime_freeze_ctrl
// Desc   : Directed plus random bench for slime_freeze_ctrl against a
//          remaining-ticks reference model.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_slime_freeze_ctrl;

   localparam int N = 4;
   localparam int F = 4;
   localparam int T = 2;
`ifdef FREEZE_EXTEND_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          frame_tick;
   logic [9:0]    x_blue;
   logic [8:0]    y_blue;
   logic [10*N-1:0] x_slim;
   logic [9*N-1:0]  y_slim;
   logic [N-1:0]  slim_alive;
   logic [N-1:0]  frozen;
   logic [N-1:0]  thawing;
   logic          any_frozen;
   logic          freeze_evt;

   slime_freeze_ctrl #(
      .N_SLIME(N), .FOOT_X(24), .FOOT_Y(41), .SLIM_W(62), .Y_TOL(2),
      .FREEZE_TICKS(F), .THAW_TICKS(T)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .x_blue(x_blue), .y_blue(y_blue), .x_slim(x_slim), .y_slim(y_slim),
      .slim_alive(slim_alive), .frozen(frozen), .thawing(thawing),
      .any_frozen(any_frozen), .freeze_evt(freeze_evt)
   );

   always #5 clk = ~clk;

   // Scenario variables (what the bench wants on the pins)
   int       sx[N];
   int       sy[N];
   int       xb, yb;
   bit [N-1:0] alive;
   bit       tick;

   // Reference model: remaining frame ticks per slime, 0 means not frozen
   int       rem[N];
   bit       cq[N];
   bit       cp[N];
   bit       ev;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_hit(int i);
      int fx, fy;
      fx = xb + 24;
      fy = yb + 41;
      return alive[i] && (fx > sx[i]) && (fx < sx[i] + 62) && (fy + 2 > sy[i]) && (fy < sy[i] + 2);
   endfunction

   task automatic model_edge();
      bit rise;
      ev = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            rem[i] = 0; cq[i] = 0; cp[i] = 0;
         end else begin
            rise = cq[i] && !cp[i];
            if (!alive[i]) begin
               rem[i] = 0;
               cp[i]  = 0;
            end else begin
               if (rise && (EXT || rem[i] == 0)) begin
                  rem[i] = F;
                  ev     = 1'b1;
               end else if (tick && rem[i] > 0) begin
                  rem[i] = rem[i] - 1;
               end
               cp[i] = cq[i];
            end
            cq[i] = model_hit(i);
         end
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         x_slim[10*i +: 10] = 10'(sx[i]);
         y_slim[9*i +: 9]   = 9'(sy[i]);
      end
      x_blue     = 10'(xb);
      y_blue     = 9'(yb);
      slim_alive = alive;
      frame_tick = tick;
   endtask

   task automatic compare();
      logic [N-1:0] ef, et;
      for (int i = 0; i < N; i++) begin
         ef[i] = rem[i] > 0;
         et[i] = (rem[i] > 0) && (rem[i] <= T);
      end
      check("frozen", 32'(frozen), 32'(ef));
      check("thawing", 32'(thawing), 32'(et));
      check("any_frozen", 32'(any_frozen), 32'(|ef));
      check("freeze_evt", 32'(freeze_evt), 32'(ev));
   endtask

   task automatic cyc();
      apply();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic tick_cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      check("async_rst", 32'(frozen), 32'd0);
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      tick = 1'b0;
      alive = '1;
      for (int i = 0; i < N; i++) begin
         sx[i] = 800; sy[i] = 400; rem[i] = 0; cq[i] = 0; cp[i] = 0;
      end
      ev = 1'b0;
      sx[0] = 90; sy[0] = 100; xb = 100; yb = 59;

      // Reset held with contact geometry present
      cyc(); cyc();
      check("rst_frozen", 32'(frozen), 32'd0);
      check("rst_evt", 32'(freeze_evt), 32'd0);
      rst = 1'b0;
      cyc();
      check("lat_k1", 32'(frozen), 32'd0);
      cyc();
      check("lat_frz", 32'(frozen), 32'd1);
      check("lat_evt", 32'(freeze_evt), 32'd1);
      cyc();
      check("evt_pulse", 32'(freeze_evt), 32'd0);

      // Freeze/thaw timing with contact held throughout
      tick_cyc(); tick_cyc();
      check("thaw_on", 32'(thawing[0]), 32'd1);
      tick_cyc(); tick_cyc();
      check("thaw_done", 32'(frozen[0]), 32'd0);
      cyc(); cyc(); cyc();
      check("held_no_refreeze", 32'(frozen[0]), 32'd0);
      xb = 0; cyc(); cyc();
      xb = 100; cyc(); cyc();
      check("refreeze", 32'(frozen[0]), 32'd1);

      // Exclusive x bounds on channel 2
      rst_pulse();
      xb = 0; cyc();
      sx[2] = 300; sy[2] = 200;
      xb = 338; yb = 159; cyc(); cyc(); cyc();
      check("x_hi_excl", 32'(frozen), 32'd0);
      xb = 276; cyc(); cyc(); cyc();
      check("x_lo_excl", 32'(frozen), 32'd0);
      xb = 277; cyc(); cyc(); cyc();
      check("x_lo_in", 32'(frozen), 32'b0100);

      // Two channels on the same cycle, then kill channel 1
      rst_pulse();
      sx[0] = 500; sy[0] = 300; sx[1] = 500; sy[1] = 300;
      xb = 500; yb = 259;
      cyc(); cyc();
      check("two_frz", 32'(frozen), 32'b0011);
      check("two_evt", 32'(freeze_evt), 32'd1);
      cyc();
      check("two_evt_end", 32'(freeze_evt), 32'd0);
      alive = 4'b1101; cyc();
      check("kill1", 32'(frozen), 32'b0001);

      // Re-contact while thawing with one tick left
      rst_pulse();
      alive = 4'b0001; sx[0] = 90; sy[0] = 100; xb = 100; yb = 59;
      cyc(); cyc();
      xb = 0;
      tick_cyc(); tick_cyc(); tick_cyc();
      check("thaw_t1", 32'(thawing[0]), 32'd1);
      xb = 100; cyc(); cyc();
`ifdef FREEZE_EXTEND_EN
      check("ext_reload", 32'(thawing[0]), 32'd0);
      tick_cyc();
      check("ext_still", 32'(frozen[0]), 32'd1);
`else
      check("no_ext", 32'(thawing[0]), 32'd1);
      tick_cyc();
      check("no_ext_done", 32'(frozen[0]), 32'd0);
`endif

      // Random phase
      rst_pulse();
      alive = '1;
      for (int i = 0; i < N; i++) begin
         sx[i] = $urandom_range(30, 900);
         sy[i] = $urandom_range(50, 450);
      end
      for (int p = 0; p < 400; p++) begin
         int k, mode, hold;
         k    = $urandom_range(0, N-1);
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            sx[k] = $urandom_range(30, 900);
            sy[k] = $urandom_range(50, 450);
         end
         if ($urandom_range(0, 9) == 0) alive[$urandom_range(0, N-1)] ^= 1'b1;
         if (mode < 3) begin
            xb = $urandom_range(0, 1023);
            yb = $urandom_range(0, 511);
         end else if (mode < 5) begin
            case ($urandom_range(0, 3))
               0: xb = sx[k] - 24;
               1: xb = sx[k] + 62 - 24;
               2: xb = sx[k] + 1 - 24;
               default: xb = sx[k] + 61 - 24;
            endcase
            yb = sy[k] + $urandom_range(0, 5) - 3 - 41;
         end else begin
            xb = sx[k] + $urandom_range(1, 61) - 24;
            yb = sy[k] + $urandom_range(0, 3) - 1 - 41;
         end
         hold = $urandom_range(1, 8);
         for (int c = 0; c < hold; c++) begin
            tick = ($urandom_range(0, 2) == 0);
            cyc();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
